// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter sharing one single-port memory.
// Writes complete in one cycle; one read may be outstanding at a time.
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int RSP_TIMEOUT = 16
) (
  input  logic              sys_clk,
  input  logic              reset,
  // instruction requester
  input  logic              i_read_cmd_valid,
  input  logic              i_write_cmd_valid,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_write_data,
  input  logic [3:0]        i_write_data_size,
  output logic              i_cmd_ready,
  output logic [31:0]       i_read_data,
  output logic              i_read_data_valid,
  output logic              i_rsp_err,
  // data requester
  input  logic              d_read_cmd_valid,
  input  logic              d_write_cmd_valid,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_write_data,
  input  logic [3:0]        d_write_data_size,
  output logic              d_cmd_ready,
  output logic [31:0]       d_read_data,
  output logic              d_read_data_valid,
  output logic              d_rsp_err,
  // memory
  output logic              mem_read_cmd_valid,
  output logic              mem_write_cmd_valid,
  output logic              mem_write_data_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_write_data,
  output logic [3:0]        mem_write_data_size,
  input  logic [31:0]       mem_read_data,
  input  logic              mem_read_data_valid
);

  localparam int CW = $clog2(RSP_TIMEOUT + 1);

  typedef enum logic {IDLE, WAIT_RSP} state_t;

  state_t        state_reg, state_next;
  logic          last_d_reg, last_d_next;    // 1: D was granted most recently
  logic          owner_d_reg, owner_d_next;  // 1: outstanding read belongs to D
  logic [CW-1:0] cnt_reg, cnt_next;

  logic i_pend, d_pend, grant_i, grant_d, sel_write;
  logic rsp_valid, rsp_err;
  logic [31:0] rsp_data;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      last_d_reg  <= 1'b1;
      owner_d_reg <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      last_d_reg  <= last_d_next;
      owner_d_reg <= owner_d_next;
      cnt_reg     <= cnt_next;
    end
  end

  always_comb begin
    state_next           = state_reg;
    last_d_next          = last_d_reg;
    owner_d_next         = owner_d_reg;
    cnt_next             = cnt_reg;
    i_pend               = i_read_cmd_valid | i_write_cmd_valid;
    d_pend               = d_read_cmd_valid | d_write_cmd_valid;
    grant_i              = 1'b0;
    grant_d              = 1'b0;
    sel_write            = 1'b0;
    rsp_valid            = 1'b0;
    rsp_err              = 1'b0;
    rsp_data             = '0;
    mem_read_cmd_valid   = 1'b0;
    mem_write_cmd_valid  = 1'b0;
    mem_write_data_valid = 1'b0;
    mem_addr             = '0;
    mem_write_data       = '0;
    mem_write_data_size  = '0;

    if (!reset) begin
      if (state_reg == IDLE) begin
        // On a tie the port that was not granted last wins
        grant_i = i_pend && (!d_pend || last_d_reg);
        grant_d = d_pend && !grant_i;
        if (grant_i) begin
          sel_write           = i_write_cmd_valid;
          mem_addr            = i_addr;
          mem_write_data      = i_write_data;
          mem_write_data_size = i_write_data_size;
        end else if (grant_d) begin
          sel_write           = d_write_cmd_valid;
          mem_addr            = d_addr;
          mem_write_data      = d_write_data;
          mem_write_data_size = d_write_data_size;
        end
        if (grant_i || grant_d) begin
          last_d_next          = grant_d;
          mem_write_cmd_valid  = sel_write;
          mem_write_data_valid = sel_write;
          mem_read_cmd_valid   = !sel_write;
          if (!sel_write) begin
            state_next   = WAIT_RSP;
            owner_d_next = grant_d;
            cnt_next     = '0;
          end
        end
      end else begin
        // A real response beats a timeout landing in the same cycle
        if (mem_read_data_valid) begin
          rsp_valid  = 1'b1;
          rsp_data   = mem_read_data;
          state_next = IDLE;
        end else if (cnt_reg == CW'(RSP_TIMEOUT - 1)) begin
          rsp_valid  = 1'b1;
          rsp_err    = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
    end
  end

  assign i_cmd_ready       = grant_i;
  assign d_cmd_ready       = grant_d;
  assign i_read_data_valid = rsp_valid && !owner_d_reg;
  assign d_read_data_valid = rsp_valid && owner_d_reg;
  assign i_rsp_err         = rsp_err && !owner_d_reg;
  assign d_rsp_err         = rsp_err && owner_d_reg;
  assign i_read_data       = owner_d_reg ? 32'h0 : rsp_data;
  assign d_read_data       = owner_d_reg ? rsp_data : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change at negedge, outputs checked #1 later.
module tb_mem_arbiter;

  localparam int ADDR_W = 32;

  logic              sys_clk = 1'b0;
  logic              reset;
  logic              i_read_cmd_valid, i_write_cmd_valid;
  logic [ADDR_W-1:0] i_addr;
  logic [31:0]       i_write_data;
  logic [3:0]        i_write_data_size;
  logic              i_cmd_ready;
  logic [31:0]       i_read_data;
  logic              i_read_data_valid, i_rsp_err;
  logic              d_read_cmd_valid, d_write_cmd_valid;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_write_data;
  logic [3:0]        d_write_data_size;
  logic              d_cmd_ready;
  logic [31:0]       d_read_data;
  logic              d_read_data_valid, d_rsp_err;
  logic              mem_read_cmd_valid, mem_write_cmd_valid, mem_write_data_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_write_data;
  logic [3:0]        mem_write_data_size;
  logic [31:0]       mem_read_data;
  logic              mem_read_data_valid;

  int total = 0;
  int bad   = 0;

  always #5 sys_clk = ~sys_clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .RSP_TIMEOUT(16)) dut (
    .sys_clk(sys_clk), .reset(reset),
    .i_read_cmd_valid(i_read_cmd_valid), .i_write_cmd_valid(i_write_cmd_valid),
    .i_addr(i_addr), .i_write_data(i_write_data), .i_write_data_size(i_write_data_size),
    .i_cmd_ready(i_cmd_ready), .i_read_data(i_read_data),
    .i_read_data_valid(i_read_data_valid), .i_rsp_err(i_rsp_err),
    .d_read_cmd_valid(d_read_cmd_valid), .d_write_cmd_valid(d_write_cmd_valid),
    .d_addr(d_addr), .d_write_data(d_write_data), .d_write_data_size(d_write_data_size),
    .d_cmd_ready(d_cmd_ready), .d_read_data(d_read_data),
    .d_read_data_valid(d_read_data_valid), .d_rsp_err(d_rsp_err),
    .mem_read_cmd_valid(mem_read_cmd_valid), .mem_write_cmd_valid(mem_write_cmd_valid),
    .mem_write_data_valid(mem_write_data_valid), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_write_data_size(mem_write_data_size),
    .mem_read_data(mem_read_data), .mem_read_data_valid(mem_read_data_valid)
  );

  task automatic clear_inputs();
    i_read_cmd_valid = 0; i_write_cmd_valid = 0; i_addr = '0;
    i_write_data = '0; i_write_data_size = '0;
    d_read_cmd_valid = 0; d_write_cmd_valid = 0; d_addr = '0;
    d_write_data = '0; d_write_data_size = '0;
    mem_read_data = '0; mem_read_data_valid = 0;
  endtask

  task automatic step();
    @(negedge sys_clk);
  endtask

  task automatic do_reset();
    step();
    clear_inputs();
    reset = 1;
    step();
    reset = 0;
  endtask

  task automatic test_reset();
    step();
    reset = 1;
    i_read_cmd_valid = 1; d_write_cmd_valid = 1; mem_read_data_valid = 1;
    mem_read_data = 32'hFFFF_FFFF;
    #1;
    total++;
    if ({i_cmd_ready, d_cmd_ready, mem_read_cmd_valid, mem_write_cmd_valid,
         mem_write_data_valid, i_read_data_valid, d_read_data_valid,
         i_rsp_err, d_rsp_err} !== 9'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 0", {i_cmd_ready, d_cmd_ready,
               mem_read_cmd_valid, mem_write_cmd_valid, mem_write_data_valid,
               i_read_data_valid, d_read_data_valid, i_rsp_err, d_rsp_err});
    end
    total++;
    if ({mem_addr, mem_write_data, i_read_data, d_read_data} !== '0) begin
      bad++;
      $display("FAIL reset_data: addr=%h wd=%h ird=%h drd=%h want 0",
               mem_addr, mem_write_data, i_read_data, d_read_data);
    end
    $display("test_reset: outputs held low during reset");
    do_reset();
  endtask

  // Tie on reads: I first, D granted the cycle after I's response
  task automatic test_tie_read();
    i_read_cmd_valid = 1; i_addr = 32'h100;
    d_read_cmd_valid = 1; d_addr = 32'h200;
    #1;
    total++;
    if ({i_cmd_ready, d_cmd_ready, mem_read_cmd_valid, mem_write_cmd_valid} !== 4'b1010
        || mem_addr !== 32'h100) begin
      bad++;
      $display("FAIL tie_grant: rdy/rd/wr=%b addr=%h want 1010 addr=100",
               {i_cmd_ready, d_cmd_ready, mem_read_cmd_valid, mem_write_cmd_valid}, mem_addr);
    end
    step();
    i_read_cmd_valid = 0;
    #1;
    total++;
    if ({i_cmd_ready, d_cmd_ready, mem_read_cmd_valid, i_read_data_valid} !== 4'b0) begin
      bad++;
      $display("FAIL wait_block: got %b want 0000",
               {i_cmd_ready, d_cmd_ready, mem_read_cmd_valid, i_read_data_valid});
    end
    step();
    mem_read_data_valid = 1; mem_read_data = 32'h0000_0013;
    #1;
    total++;
    if (i_read_data_valid !== 1'b1 || i_read_data !== 32'h13 || d_read_data_valid !== 1'b0
        || d_read_data !== 32'h0 || i_rsp_err !== 1'b0 || d_cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL i_rsp: iv=%b id=%h dv=%b dd=%h err=%b drdy=%b want 1 13 0 0 0 0",
               i_read_data_valid, i_read_data, d_read_data_valid, d_read_data,
               i_rsp_err, d_cmd_ready);
    end
    $display("test_tie_read: I read 0x100 -> %h", i_read_data);
    step();
    mem_read_data_valid = 0; mem_read_data = '0;
    #1;
    total++;
    if (d_cmd_ready !== 1'b1 || i_cmd_ready !== 1'b0 || mem_read_cmd_valid !== 1'b1
        || mem_addr !== 32'h200 || i_read_data_valid !== 1'b0) begin
      bad++;
      $display("FAIL d_grant: drdy=%b irdy=%b rd=%b addr=%h iv=%b want 1 0 1 200 0",
               d_cmd_ready, i_cmd_ready, mem_read_cmd_valid, mem_addr, i_read_data_valid);
    end
    step();
    d_read_cmd_valid = 0;
    mem_read_data_valid = 1; mem_read_data = 32'hDEAD_0001;
    #1;
    total++;
    if (d_read_data_valid !== 1'b1 || d_read_data !== 32'hDEAD_0001
        || i_read_data_valid !== 1'b0 || i_read_data !== 32'h0) begin
      bad++;
      $display("FAIL d_rsp: dv=%b dd=%h iv=%b id=%h want 1 dead0001 0 0",
               d_read_data_valid, d_read_data, i_read_data_valid, i_read_data);
    end
    $display("test_tie_read: D read 0x200 -> %h", d_read_data);
    step();
    clear_inputs();
  endtask

  task automatic test_write();
    d_write_cmd_valid = 1; d_addr = 32'h40;
    d_write_data = 32'hA5A5_5A5A; d_write_data_size = 4'hF;
    #1;
    total++;
    if ({d_cmd_ready, i_cmd_ready, mem_write_cmd_valid, mem_write_data_valid,
         mem_read_cmd_valid} !== 5'b10110 || mem_addr !== 32'h40
        || mem_write_data !== 32'hA5A5_5A5A || mem_write_data_size !== 4'hF) begin
      bad++;
      $display("FAIL d_write: ctl=%b addr=%h wd=%h sz=%h want 10110 40 a5a55a5a f",
               {d_cmd_ready, i_cmd_ready, mem_write_cmd_valid, mem_write_data_valid,
                mem_read_cmd_valid}, mem_addr, mem_write_data, mem_write_data_size);
    end
    $display("test_write: D write 0x40 <= %h", mem_write_data);
    step();
    d_write_cmd_valid = 0;
    #1;
    total++;
    if ({mem_write_cmd_valid, mem_write_data_valid, mem_read_cmd_valid} !== 3'b0) begin
      bad++;
      $display("FAIL write_one_cycle: got %b want 000",
               {mem_write_cmd_valid, mem_write_data_valid, mem_read_cmd_valid});
    end
    // Read+write together on I counts as a write; still IDLE so granted at once
    i_read_cmd_valid = 1; i_write_cmd_valid = 1; i_addr = 32'h44;
    i_write_data = 32'h1234_5678; i_write_data_size = 4'h3;
    #1;
    total++;
    if ({i_cmd_ready, mem_write_cmd_valid, mem_read_cmd_valid} !== 3'b110
        || mem_addr !== 32'h44 || mem_write_data_size !== 4'h3) begin
      bad++;
      $display("FAIL rw_as_write: ctl=%b addr=%h sz=%h want 110 44 3",
               {i_cmd_ready, mem_write_cmd_valid, mem_read_cmd_valid}, mem_addr,
               mem_write_data_size);
    end
    $display("test_write: I rd+wr 0x44 treated as write");
    step();
    clear_inputs();
    // Stray response in IDLE must be ignored and not block the next grant
    mem_read_data_valid = 1; mem_read_data = 32'hBAD0_BAD0;
    #1;
    total++;
    if ({i_read_data_valid, d_read_data_valid, i_rsp_err, d_rsp_err} !== 4'b0
        || i_read_data !== 32'h0 || d_read_data !== 32'h0) begin
      bad++;
      $display("FAIL idle_rsp: valids=%b id=%h dd=%h want 0",
               {i_read_data_valid, d_read_data_valid, i_rsp_err, d_rsp_err},
               i_read_data, d_read_data);
    end
    step();
    mem_read_data_valid = 0;
    d_write_cmd_valid = 1; d_addr = 32'h48;
    #1;
    total++;
    if (d_cmd_ready !== 1'b1 || mem_write_cmd_valid !== 1'b1) begin
      bad++;
      $display("FAIL idle_after_rsp: drdy=%b wr=%b want 1 1", d_cmd_ready, mem_write_cmd_valid);
    end
    step();
    clear_inputs();
  endtask

  // race=0: silent memory -> timeout on 16th wait cycle; race=1: response arrives that cycle
  task automatic test_timeout(input bit race);
    bit seen_early = 0;
    i_read_cmd_valid = 1; i_addr = 32'h300;
    #1;
    total++;
    if (i_cmd_ready !== 1'b1 || mem_read_cmd_valid !== 1'b1) begin
      bad++;
      $display("FAIL to_grant: irdy=%b rd=%b want 1 1", i_cmd_ready, mem_read_cmd_valid);
    end
    for (int k = 1; k <= 16; k++) begin
      step();
      i_read_cmd_valid = 0;
      if (k == 16 && race) begin
        mem_read_data_valid = 1; mem_read_data = 32'h0000_00AB;
      end
      #1;
      if (k < 16 && (i_read_data_valid || i_rsp_err || d_read_data_valid)) seen_early = 1;
    end
    total++;
    if (seen_early) begin
      bad++;
      $display("FAIL to_early: response seen before wait cycle 16, want none");
    end
    total++;
    if (race) begin
      if (i_read_data_valid !== 1'b1 || i_rsp_err !== 1'b0 || i_read_data !== 32'hAB) begin
        bad++;
        $display("FAIL to_race: iv=%b err=%b id=%h want 1 0 ab",
                 i_read_data_valid, i_rsp_err, i_read_data);
      end
    end else begin
      if (i_read_data_valid !== 1'b1 || i_rsp_err !== 1'b1 || i_read_data !== 32'h0
          || d_read_data_valid !== 1'b0 || d_rsp_err !== 1'b0) begin
        bad++;
        $display("FAIL to_fire: iv=%b err=%b id=%h dv=%b derr=%b want 1 1 0 0 0",
                 i_read_data_valid, i_rsp_err, i_read_data, d_read_data_valid, d_rsp_err);
      end
    end
    $display("test_timeout race=%0d: I read 0x300 done err=%b", race, i_rsp_err);
    step();
    clear_inputs();
    d_write_cmd_valid = 1; d_addr = 32'h304;
    #1;
    total++;
    if (d_cmd_ready !== 1'b1 || i_rsp_err !== 1'b0 || i_read_data_valid !== 1'b0) begin
      bad++;
      $display("FAIL to_idle: drdy=%b err=%b iv=%b want 1 0 0",
               d_cmd_ready, i_rsp_err, i_read_data_valid);
    end
    step();
    clear_inputs();
  endtask

  task automatic test_reset_in_wait();
    // D reads so that last_grant is D-not-default only via reset afterwards
    d_read_cmd_valid = 1; d_addr = 32'h500;
    #1;
    step();
    clear_inputs();
    reset = 1;
    #1;
    total++;
    if ({i_cmd_ready, d_cmd_ready, d_read_data_valid, d_rsp_err} !== 4'b0) begin
      bad++;
      $display("FAIL rw_reset_out: got %b want 0000",
               {i_cmd_ready, d_cmd_ready, d_read_data_valid, d_rsp_err});
    end
    step();
    reset = 0;
    mem_read_data_valid = 1; mem_read_data = 32'h5555_AAAA;
    #1;
    total++;
    if ({i_read_data_valid, d_read_data_valid, i_rsp_err, d_rsp_err} !== 4'b0
        || d_read_data !== 32'h0) begin
      bad++;
      $display("FAIL late_rsp: valids=%b dd=%h want 0 0",
               {i_read_data_valid, d_read_data_valid, i_rsp_err, d_rsp_err}, d_read_data);
    end
    step();
    mem_read_data_valid = 0;
    i_read_cmd_valid = 1; i_addr = 32'h600;
    d_read_cmd_valid = 1; d_addr = 32'h700;
    #1;
    total++;
    if (i_cmd_ready !== 1'b1 || d_cmd_ready !== 1'b0 || mem_addr !== 32'h600) begin
      bad++;
      $display("FAIL post_reset_tie: irdy=%b drdy=%b addr=%h want 1 0 600",
               i_cmd_ready, d_cmd_ready, mem_addr);
    end
    $display("test_reset_in_wait: late response dropped, I granted 0x600");
    do_reset();
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp_i, got_i, got_d;
    exp_i = 12'b1010_1010_1010;  // bit 11 is the first cycle: I,D,I,D,...
    got_i = '0; got_d = '0;
    i_write_cmd_valid = 1; i_addr = 32'h10;
    d_write_cmd_valid = 1; d_addr = 32'h20;
    for (int c = 11; c >= 0; c--) begin
      #1;
      got_i[c] = i_cmd_ready;
      got_d[c] = d_cmd_ready;
      step();
    end
    total++;
    if (got_i !== exp_i || got_d !== ~exp_i) begin
      bad++;
      $display("FAIL alternate: i=%b d=%b want i=%b d=%b", got_i, got_d, exp_i, ~exp_i);
    end
    $display("test_back_to_back: grants i=%b d=%b", got_i, got_d);
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    step();
    test_reset();
    test_tie_read();
    test_write();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_in_wait();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
